// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access controller
// Runs one SRAM-like bus transaction per memory instruction, stalls until it completes, drains flushed accesses.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_adv,
   input  logic        flush,
   input  logic        exc_any,
   input  logic        wmem,
   input  logic [3:0]  load_type,
   input  logic [3:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        mem_stall,
   output logic [31:0] load_result,
   output logic        load_result_valid
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        is_load, access;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  ltype_q, ltype_d;
   logic [31:0] result_q, result_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  req_size;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ext;

   assign is_load = (load_type >= 4'd1) && (load_type <= 4'd5);
   assign access  = mem_valid & ~exc_any & (wmem | is_load);

   // Request fields as presented by the EXE/MEM register; stores take priority over load_type
   always_comb begin
      req_size  = 2'd2;
      req_wstrb = 4'b0000;
      req_wdata = 32'h0;
      if (wmem) begin
         case (store_type)
            4'd1: begin
               req_size  = 2'd0;
               req_wstrb = 4'b0001 << addr[1:0];
               req_wdata = {4{wdata[7:0]}};
            end
            4'd2: begin
               req_size  = 2'd1;
               req_wstrb = addr[1] ? 4'b1100 : 4'b0011;
               req_wdata = {2{wdata[15:0]}};
            end
            4'd3: begin
               req_wstrb = 4'b1111;
               req_wdata = wdata;
            end
            default: req_wdata = wdata;
         endcase
      end else begin
         case (load_type)
            4'd1, 4'd2: req_size = 2'd0;
            4'd3, 4'd4: req_size = 2'd1;
            default:    req_size = 2'd2;
         endcase
      end
   end

   always_comb begin
      rd_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
      rd_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (ltype_q)
         4'd1:    ext = {{24{rd_byte[7]}}, rd_byte};
         4'd2:    ext = {24'h0, rd_byte};
         4'd3:    ext = {{16{rd_half[15]}}, rd_half};
         4'd4:    ext = {16'h0, rd_half};
         default: ext = data_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= 32'h0;
         wstrb_q  <= 4'h0;
         wdata_q  <= 32'h0;
         ltype_q  <= 4'h0;
         result_q <= 32'h0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         ltype_q  <= ltype_d;
         result_q <= result_d;
         rvalid_q <= rvalid_d;
      end
   end

   // A flush seen with the request outstanding sends the FSM to DRAIN so the orphan response is swallowed
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (access && !flush) state_d = S_REQ;
         S_REQ:   if (flush) state_d = S_IDLE;
                  else if (data_addr_ok) state_d = S_WAIT;
         S_WAIT:  if (data_data_ok) state_d = flush ? S_IDLE : S_DONE;
                  else if (flush) state_d = S_DRAIN;
         S_DONE:  if (mem_adv || flush) state_d = S_IDLE;
         S_DRAIN: if (data_data_ok) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_d     = wr_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      ltype_d  = ltype_q;
      result_d = result_q;
      rvalid_d = rvalid_q;
      if (state_q == S_IDLE && state_d == S_REQ) begin
         wr_d    = wmem;
         size_d  = req_size;
         addr_d  = addr;
         wstrb_d = req_wstrb;
         wdata_d = req_wdata;
         ltype_d = load_type;
      end
      if (state_q == S_WAIT && state_d == S_DONE && !wr_q) begin
         result_d = ext;
         rvalid_d = 1'b1;
      end
      if (state_q == S_DONE && state_d != S_DONE) rvalid_d = 1'b0;
   end

   always_comb begin
      data_req  = (state_q == S_REQ) & ~flush;
      mem_stall = access & (state_q != S_DONE);
   end

   assign data_wr           = wr_q;
   assign data_size         = size_q;
   assign data_addr         = addr_q;
   assign data_wstrb        = wstrb_q;
   assign data_wdata        = wdata_q;
   assign load_result       = result_q;
   assign load_result_valid = rvalid_q;
endmodule
